// File: rtl/md_stall_ctrl.sv
// HI/LO mult/div busy tracker and F/D stall/bubble generator for the 5-stage pipeline.
// Optional stall statistics counters are enabled by defining MD_STALL_STAT_EN.
module md_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             E_md_start,
  input  logic             E_md_is_div,
  input  logic             D_md_use,
  input  logic             hzd_stall,
  output logic             stall,
  output logic             F_en,
  output logic             D_en,
  output logic             E_clr,
  output logic             md_busy,
  output logic             md_done,
  output logic [1:0]       md_state,
  output logic [CNT_W-1:0] md_cnt
`ifdef MD_STALL_STAT_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      md_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    MULT_BUSY = 2'b01,
    DIV_BUSY  = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_md_stall;

  // A new start reloads even while busy and wins over the last-cycle exit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (E_md_start) begin
      if (E_md_is_div) begin
        w_state_nxt = DIV_BUSY;
        w_cnt_nxt   = CNT_W'(DIV_CYCLES);
      end else begin
        w_state_nxt = MULT_BUSY;
        w_cnt_nxt   = CNT_W'(MULT_CYCLES);
      end
    end else if (r_state != IDLE) begin
      if (r_cnt <= CNT_W'(1)) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign md_busy  = (r_state != IDLE);
  assign md_done  = md_busy && (r_cnt == CNT_W'(1));
  assign md_state = r_state;
  assign md_cnt   = r_cnt;

  // The start cycle itself counts as busy so a dependent instr right behind it is held.
  assign w_md_stall = reset & D_md_use & (md_busy | E_md_start);
  assign stall      = reset & (hzd_stall | w_md_stall);
  assign F_en       = ~stall;
  assign D_en       = ~stall;
  assign E_clr      = stall;

`ifdef MD_STALL_STAT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_md_stall_cycles;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cycles    <= '0;
      r_md_stall_cycles <= '0;
    end else begin
      if (stall)      r_stall_cycles    <= r_stall_cycles + 32'd1;
      if (w_md_stall) r_md_stall_cycles <= r_md_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles    = r_stall_cycles;
  assign md_stall_cycles = r_md_stall_cycles;
`endif

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Scoreboard bench for md_stall_ctrl: a timestamp model of the busy window predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_md_stall_ctrl;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;
  localparam int unsigned CW     = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset       = 1'b0;
  logic E_md_start  = 1'b0;
  logic E_md_is_div = 1'b0;
  logic D_md_use    = 1'b0;
  logic hzd_stall   = 1'b0;
  logic stall, F_en, D_en, E_clr, md_busy, md_done;
  logic [1:0]    md_state;
  logic [CW-1:0] md_cnt;
`ifdef MD_STALL_STAT_EN
  logic [31:0] stall_cycles, md_stall_cycles;
`endif

  md_stall_ctrl #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .E_md_start (E_md_start),
    .E_md_is_div(E_md_is_div),
    .D_md_use   (D_md_use),
    .hzd_stall  (hzd_stall),
    .stall      (stall),
    .F_en       (F_en),
    .D_en       (D_en),
    .E_clr      (E_clr),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .md_state   (md_state),
    .md_cnt     (md_cnt)
`ifdef MD_STALL_STAT_EN
    ,
    .stall_cycles   (stall_cycles),
    .md_stall_cycles(md_stall_cycles)
`endif
  );

  typedef struct {
    longint      cyc;
    logic        stall, fen, den, eclr, busy, done;
    logic [1:0]  st;
    logic [31:0] cnt;
    logic [31:0] sc, msc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Model: the unit is busy in every cycle c with c <= end_cyc; op 1=mult, 2=div.
  longint      cyc     = 0;
  longint      end_cyc = -1;
  int          op      = 0;
  bit          rst_seen = 1'b0;
  logic [31:0] m_sc  = '0;
  logic [31:0] m_msc = '0;

  function automatic bit m_busy();
    return rst_seen && (cyc <= end_cyc);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input longint c);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit s, input bit d, input bit u, input bit h);
    bit   busy, mds, st;
    exp_t e;
    @(posedge clk);
    busy = m_busy();
    mds  = reset && D_md_use && (busy || E_md_start);
    st   = reset && (hzd_stall || mds);
    if (!reset) begin
      end_cyc  = cyc;
      m_sc     = '0;
      m_msc    = '0;
      rst_seen = 1'b1;
    end else begin
      if (st)  m_sc++;
      if (mds) m_msc++;
      if (E_md_start) begin
        end_cyc = cyc + (E_md_is_div ? DIV_N : MULT_N);
        op      = E_md_is_div ? 2 : 1;
      end
    end
    cyc++;
    #1;
    reset = r; E_md_start = s; E_md_is_div = d; D_md_use = u; hzd_stall = h;
    busy  = m_busy();
    e.cyc  = cyc;
    e.busy = busy;
    e.cnt  = busy ? 32'(end_cyc - cyc + 1) : 32'd0;
    e.st   = busy ? 2'(op) : 2'd0;
    e.done = busy && (e.cnt == 1);
    mds    = r && u && (busy || s);
    e.stall = r && (h || mds);
    e.fen  = !e.stall;
    e.den  = !e.stall;
    e.eclr = e.stall;
    e.sc   = m_sc;
    e.msc  = m_msc;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall",    32'(stall),    32'(e.stall), e.cyc);
      chk("F_en",     32'(F_en),     32'(e.fen),   e.cyc);
      chk("D_en",     32'(D_en),     32'(e.den),   e.cyc);
      chk("E_clr",    32'(E_clr),    32'(e.eclr),  e.cyc);
      chk("md_busy",  32'(md_busy),  32'(e.busy),  e.cyc);
      chk("md_done",  32'(md_done),  32'(e.done),  e.cyc);
      chk("md_state", 32'(md_state), 32'(e.st),    e.cyc);
      chk("md_cnt",   32'(md_cnt),   e.cnt,        e.cyc);
`ifdef MD_STALL_STAT_EN
      chk("stall_cycles",    stall_cycles,    e.sc,  e.cyc);
      chk("md_stall_cycles", md_stall_cycles, e.msc, e.cyc);
`endif
    end
  end

  initial begin
    // Reset held with start and md use asserted
    drive(0, 1, 0, 1, 0);
    drive(0, 1, 1, 1, 1);
    drive(1, 0, 0, 0, 0);
    // Mult timing
    drive(1, 1, 0, 0, 0);
    repeat (7) drive(1, 0, 0, 0, 0);
    // Div with dependent mflo held through busy window, then released
    drive(1, 1, 1, 1, 0);
    repeat (12) drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    // Independent instrs overlapping a div
    drive(1, 1, 1, 0, 0);
    repeat (11) drive(1, 0, 0, 0, 0);
    // hzd_stall together with md stall
    drive(1, 1, 1, 1, 1);
    repeat (5) drive(1, 0, 0, 1, 1);
    repeat (6) drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    // Forced restart on the last mult cycle
    drive(1, 1, 0, 0, 0);
    repeat (4) drive(1, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    repeat (11) drive(1, 0, 0, 0, 0);
    // Reset in the middle of a div at md_cnt == 6
    drive(1, 1, 1, 0, 0);
    repeat (4) drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    repeat (12) drive(1, 0, 0, 0, 0);
    // Randomized traffic, including illegal restarts while busy
    for (int i = 0; i < 3000; i++) begin
      bit r, s, d, u, h;
      r = ($urandom_range(0, 99) >= 2);
      s = ($urandom_range(0, 99) < 12);
      d = $urandom_range(0, 1) == 1;
      u = ($urandom_range(0, 99) < 40);
      h = ($urandom_range(0, 99) < 10);
      drive(r, s, d, u, h);
    end
    drive(1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
